// File: rtl/zeroriscy_htif_pkg.sv
// zeroriscy_htif_pkg
//   Shared definitions for the HTIF slave: default address map, console status
//   word layout and the response FSM state type. A small helper packs the
//   console status word so the layout lives in one place.
package zeroriscy_htif_pkg;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT  = 32'h8000_1000;
  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h9A10_0000;

  // FROMHOST sits 0x40 bytes above TOHOST (16 words)
  localparam logic [29:0] FROMHOST_WORD_OFFSET = 30'h10;

  // Console status word: {zeros, count[6:0], full, empty}
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_t;

  function automatic logic [31:0] status_word(input logic [STATUS_COUNT_W-1:0] count,
                                              input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[STATUS_COUNT_LSB +: STATUS_COUNT_W] = count;
    w[STATUS_FULL_BIT]  = full;
    w[STATUS_EMPTY_BIT] = empty;
    return w;
  endfunction

endpackage

// File: rtl/zeroriscy_htif_fifo.sv
// zeroriscy_htif_fifo
//   Byte FIFO for the console stream. Power-of-two depth, so the read and
//   write pointers simply wrap; occupancy is tracked by a separate counter
//   which also yields full/empty.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   push, push_data - enqueue one byte (ignored when full)
//   pop          - dequeue the head byte (ignored when empty)
//   pop_data     - current head byte
//   full, empty  - derived from the registered count
//   count        - number of bytes held (0..DEPTH)
module zeroriscy_htif_fifo
  import zeroriscy_htif_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zeroriscy_htif_slave.sv
// zeroriscy_htif_slave
//   Data-bus slave for a zero-riscy core exposing a TOHOST word, a console
//   byte stream (data + status registers backed by a FIFO) and, optionally,
//   a FROMHOST word. Grants are combinational; every grant produces one
//   response cycle later. Unmapped accesses answer with an error.
// Optional feature macro: ZERORISCY_HTIF_FROMHOST_EN adds fromhost_we_i,
//   fromhost_data_i and a FROMHOST register at TOHOST_ADDR + 0x40.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   data_req_i .. data_wdata_i - core request (address, we, byte enables, data)
//   data_gnt_o                 - request accepted this cycle
//   data_rvalid_o, data_rdata_o, data_err_o - response one cycle after grant
//   tohost_valid_o, tohost_data_o - pulse + last word written to TOHOST
//   cons_valid_o, cons_data_o, cons_ready_i - console byte stream
//   fromhost_we_i, fromhost_data_i - host-side FROMHOST load (macro only)
module zeroriscy_htif_slave
  import zeroriscy_htif_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEFAULT,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        tohost_valid_o,
  output logic [31:0] tohost_data_o,
`ifdef ZERORISCY_HTIF_FROMHOST_EN
  input  logic        fromhost_we_i,
  input  logic [31:0] fromhost_data_i,
`endif
  output logic        cons_valid_o,
  output logic [7:0]  cons_data_o,
  input  logic        cons_ready_i
);

  localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [29:0] TOHOST_W    = TOHOST_ADDR[31:2];
  localparam logic [29:0] CONS_DATA_W = CONSOLE_ADDR[31:2];
  localparam logic [29:0] CONS_STAT_W = CONSOLE_ADDR[31:2] + 30'h1;

  logic [29:0]        word_addr;
  logic               hit_tohost;
  logic               hit_cons_data;
  logic               hit_cons_stat;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [31:0]        rdata_next;
  logic               err_next;
  resp_state_t        state;
  logic               unused_bits;

  // Byte lanes above lane 0 and the sub-word address bits carry no meaning here.
  assign unused_bits = ^{data_addr_i[1:0], data_be_i[3:1]};

  assign word_addr     = data_addr_i[31:2];
  assign hit_tohost    = (word_addr == TOHOST_W);
  assign hit_cons_data = (word_addr == CONS_DATA_W);
  assign hit_cons_stat = (word_addr == CONS_STAT_W);

`ifdef ZERORISCY_HTIF_FROMHOST_EN
  localparam logic [29:0] FROMHOST_W = TOHOST_W + FROMHOST_WORD_OFFSET;
  logic        hit_fromhost;
  logic [31:0] fromhost_q;
  assign hit_fromhost = (word_addr == FROMHOST_W);
`endif

  // A console-data write cannot be accepted while the FIFO is full, even if a
  // pop happens this cycle, since full comes from the registered count.
  assign data_gnt_o = data_req_i & ~reset & ~(hit_cons_data & data_we_i & fifo_full);

  assign fifo_push    = data_gnt_o & data_we_i & hit_cons_data & data_be_i[0];
  assign fifo_pop     = cons_valid_o & cons_ready_i;
  assign cons_valid_o = ~fifo_empty;

  zeroriscy_htif_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (data_wdata_i[7:0]),
    .pop       (fifo_pop),
    .pop_data  (cons_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Response payload for the current request; writes to mapped registers
  // return zero data, unmapped accesses flag an error.
  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    if (hit_tohost) begin
      if (!data_we_i) rdata_next = tohost_data_o;
    end else if (hit_cons_data) begin
      rdata_next = '0;
    end else if (hit_cons_stat) begin
      if (!data_we_i) rdata_next = status_word(STATUS_COUNT_W'(fifo_count), fifo_full, fifo_empty);
`ifdef ZERORISCY_HTIF_FROMHOST_EN
    end else if (hit_fromhost) begin
      if (!data_we_i) rdata_next = fromhost_q;
`endif
    end else begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      data_rvalid_o  <= 1'b0;
      data_rdata_o   <= '0;
      data_err_o     <= 1'b0;
      tohost_valid_o <= 1'b0;
      tohost_data_o  <= '0;
    end else begin
      case (state)
        IDLE:    state <= data_gnt_o ? RESP : IDLE;
        RESP:    state <= data_gnt_o ? RESP : IDLE;
        default: state <= IDLE;
      endcase
      data_rvalid_o  <= data_gnt_o;
      tohost_valid_o <= 1'b0;
      if (data_gnt_o) begin
        data_rdata_o <= rdata_next;
        data_err_o   <= err_next;
        if (data_we_i && hit_tohost) begin
          tohost_data_o  <= data_wdata_i;
          tohost_valid_o <= 1'b1;
        end
      end
    end
  end

`ifdef ZERORISCY_HTIF_FROMHOST_EN
  // Host load wins over a core clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      fromhost_q <= '0;
    end else if (fromhost_we_i) begin
      fromhost_q <= fromhost_data_i;
    end else if (data_gnt_o && data_we_i && hit_fromhost) begin
      fromhost_q <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_zeroriscy_htif_slave.sv
// tb_zeroriscy_htif_slave
//   Directed bench for the HTIF slave: a table of single-cycle bus accesses
//   with hand-computed responses, followed by hand-written sequences for the
//   console stream, FIFO-full stall, reset mid-transaction and (when the
//   ZERORISCY_HTIF_FROMHOST_EN macro is defined) the FROMHOST register.
module tb_zeroriscy_htif_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        tohost_valid_o;
  logic [31:0] tohost_data_o;
  logic        cons_valid_o;
  logic [7:0]  cons_data_o;
  logic        cons_ready_i;
`ifdef ZERORISCY_HTIF_FROMHOST_EN
  logic        fromhost_we_i;
  logic [31:0] fromhost_data_i;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A_TOHOST = 32'h8000_1000;
  localparam logic [31:0] A_FROM   = 32'h8000_1040;
  localparam logic [31:0] A_CDATA  = 32'h9A10_0000;
  localparam logic [31:0] A_CSTAT  = 32'h9A10_0004;

  zeroriscy_htif_slave dut (
    .clk            (clk),
    .reset          (reset),
    .data_req_i     (data_req_i),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .tohost_valid_o (tohost_valid_o),
    .tohost_data_o  (tohost_data_o),
`ifdef ZERORISCY_HTIF_FROMHOST_EN
    .fromhost_we_i  (fromhost_we_i),
    .fromhost_data_i(fromhost_data_i),
`endif
    .cons_valid_o   (cons_valid_o),
    .cons_data_o    (cons_data_o),
    .cons_ready_i   (cons_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic        chk_resp;
    logic        exp_err;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_th_valid;
    logic [31:0] exp_th_data;
  } vec_t;

  vec_t vecs[13];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic [31:0] addr, input logic we,
                                input logic [3:0] be, input logic [31:0] wdata);
    data_req_i   = req;
    data_addr_i  = addr;
    data_we_i    = we;
    data_be_i    = be;
    data_wdata_i = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One granted-or-not access: drive, check grant, advance past the edge.
  task automatic bus_access(input string name, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic exp_gnt);
    apply_stimulus(1'b1, addr, we, 4'hF, wdata);
    #1;
    check_output({name, "_gnt"}, 32'(data_gnt_o), 32'(exp_gnt));
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Bus accesses with cons_ready_i high; tohost_data tracks every write.
    vecs[0]  = '{1'b1, A_TOHOST,      1'b1, 4'hF, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0000_0001};
    vecs[1]  = '{1'b1, A_TOHOST,      1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0001,  1'b0, 32'h0000_0001};
    vecs[2]  = '{1'b1, A_TOHOST,      1'b1, 4'h1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 32'h8000_1003, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF,  1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h1234_5678, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0000_0000, 1'b1, 4'hF, 32'h0000_0005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, A_CDATA,       1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, A_CSTAT,       1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0001,  1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, A_CSTAT,       1'b1, 4'hF, 32'h0000_00FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,          1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 32'h9A10_0007, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0001,  1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, A_TOHOST,      1'b1, 4'hF, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          1'b0, 32'hDEAD_BEEF};
`ifdef ZERORISCY_HTIF_FROMHOST_EN
    vecs[11] = '{1'b1, A_FROM,        1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};
`else
    vecs[11] = '{1'b1, A_FROM,        1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};
`endif
    vecs[12] = '{1'b1, 32'h8000_1004, 1'b1, 4'hF, 32'h0000_0009, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,          1'b0, 32'hDEAD_BEEF};

    // Reset with a write request pending: nothing may be granted or loaded.
    reset        = 1'b1;
    cons_ready_i = 1'b0;
`ifdef ZERORISCY_HTIF_FROMHOST_EN
    fromhost_we_i   = 1'b0;
    fromhost_data_i = 32'h0;
`endif
    apply_stimulus(1'b1, A_TOHOST, 1'b1, 4'hF, 32'h0000_0055);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_gnt",      32'(data_gnt_o),     32'h0);
    check_output("rst_rvalid",   32'(data_rvalid_o),  32'h0);
    check_output("rst_err",      32'(data_err_o),     32'h0);
    check_output("rst_rdata",    data_rdata_o,        32'h0);
    check_output("rst_th_valid", 32'(tohost_valid_o), 32'h0);
    check_output("rst_th_data",  tohost_data_o,       32'h0);
    check_output("rst_cvalid",   32'(cons_valid_o),   32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    reset = 1'b0;
    next_cycle();

    // Table-driven back-to-back accesses.
    $display("[TB] table vectors");
    cons_ready_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].req, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
      #1;
      check_output($sformatf("vec%0d_gnt", i), 32'(data_gnt_o), 32'(vecs[i].exp_gnt));
      next_cycle();
      check_output($sformatf("vec%0d_rvalid", i), 32'(data_rvalid_o), 32'(vecs[i].exp_rvalid));
      if (vecs[i].chk_resp)
        check_output($sformatf("vec%0d_err", i), 32'(data_err_o), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdata)
        check_output($sformatf("vec%0d_rdata", i), data_rdata_o, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d_th_valid", i), 32'(tohost_valid_o), 32'(vecs[i].exp_th_valid));
      check_output($sformatf("vec%0d_th_data", i), tohost_data_o, vecs[i].exp_th_data);
    end
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    next_cycle();

    // "Hi" on the console with the consumer always ready.
    $display("[TB] console stream");
    apply_stimulus(1'b1, A_CDATA, 1'b1, 4'h1, 32'h0000_0048);
    #1;
    check_output("hi_H_gnt", 32'(data_gnt_o), 32'h1);
    next_cycle();
    check_output("hi_H_valid", 32'(cons_valid_o), 32'h1);
    check_output("hi_H_data",  32'(cons_data_o),  32'h48);
    apply_stimulus(1'b1, A_CDATA, 1'b1, 4'h1, 32'h0000_0069);
    #1;
    check_output("hi_i_gnt", 32'(data_gnt_o), 32'h1);
    next_cycle();
    check_output("hi_i_valid", 32'(cons_valid_o), 32'h1);
    check_output("hi_i_data",  32'(cons_data_o),  32'h69);
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    next_cycle();
    check_output("hi_drained", 32'(cons_valid_o), 32'h0);
    bus_access("hi_stat", A_CSTAT, 1'b0, 32'h0, 1'b1);
    check_output("hi_stat_rvalid", 32'(data_rvalid_o), 32'h1);
    check_output("hi_stat_rdata",  data_rdata_o,       32'h1);

    // Byte-lane 0 disabled: acknowledged, nothing enqueued.
    cons_ready_i = 1'b0;
    apply_stimulus(1'b1, A_CDATA, 1'b1, 4'hE, 32'h0000_0077);
    #1;
    check_output("be0_gnt", 32'(data_gnt_o), 32'h1);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    check_output("be0_rvalid", 32'(data_rvalid_o), 32'h1);
    check_output("be0_nopush", 32'(cons_valid_o),  32'h0);

    // Fill the FIFO with the consumer stalled, then stall the ninth write.
    $display("[TB] fifo full stall");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, A_CDATA, 1'b1, 4'h1, 32'h10 + 32'(i));
      #1;
      check_output($sformatf("fill%0d_gnt", i), 32'(data_gnt_o), 32'h1);
      next_cycle();
    end
    bus_access("full_stat", A_CSTAT, 1'b0, 32'h0, 1'b1);
    check_output("full_stat_rdata", data_rdata_o,       32'h22);
    check_output("full_head",       32'(cons_data_o),   32'h10);
    apply_stimulus(1'b1, A_CDATA, 1'b1, 4'h1, 32'h0000_0018);
    #1;
    check_output("ninth_gnt_c0", 32'(data_gnt_o), 32'h0);
    next_cycle();
    check_output("ninth_rvalid_c0", 32'(data_rvalid_o), 32'h0);
    check_output("ninth_head_hold", 32'(cons_data_o),   32'h10);
    cons_ready_i = 1'b1;
    #1;
    check_output("ninth_gnt_pop", 32'(data_gnt_o), 32'h0);
    next_cycle();
    cons_ready_i = 1'b0;
    #1;
    check_output("ninth_gnt_after", 32'(data_gnt_o),  32'h1);
    check_output("ninth_head_next", 32'(cons_data_o), 32'h11);
    next_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    check_output("ninth_rvalid", 32'(data_rvalid_o), 32'h1);
    bus_access("refull_stat", A_CSTAT, 1'b0, 32'h0, 1'b1);
    check_output("refull_stat_rdata", data_rdata_o, 32'h22);
    cons_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("drain%0d_valid", i), 32'(cons_valid_o), 32'h1);
      check_output($sformatf("drain%0d_data", i),  32'(cons_data_o),  32'h11 + 32'(i));
      next_cycle();
    end
    check_output("drain_empty", 32'(cons_valid_o), 32'h0);

    // Reset while bytes are queued and a response is on the bus.
    $display("[TB] reset mid-transaction");
    cons_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_access($sformatf("q%0d", i), A_CDATA, 1'b1, 32'hA0 + 32'(i), 1'b1);
    end
    bus_access("q_stat", A_CSTAT, 1'b0, 32'h0, 1'b1);
    check_output("q_stat_rvalid", 32'(data_rvalid_o), 32'h1);
    check_output("q_stat_rdata",  data_rdata_o,       32'h0C);
    reset = 1'b1;
    next_cycle();
    check_output("mid_rst_rvalid", 32'(data_rvalid_o), 32'h0);
    check_output("mid_rst_cvalid", 32'(cons_valid_o),  32'h0);
    reset = 1'b0;
    next_cycle();
    bus_access("post_rst_stat", A_CSTAT, 1'b0, 32'h0, 1'b1);
    check_output("post_rst_stat_rdata", data_rdata_o, 32'h1);

`ifdef ZERORISCY_HTIF_FROMHOST_EN
    $display("[TB] fromhost");
    fromhost_we_i   = 1'b1;
    fromhost_data_i = 32'h0000_00A5;
    next_cycle();
    fromhost_we_i   = 1'b0;
    bus_access("fh_rd0", A_FROM, 1'b0, 32'h0, 1'b1);
    check_output("fh_rd0_err",   32'(data_err_o), 32'h0);
    check_output("fh_rd0_rdata", data_rdata_o,    32'h0000_00A5);
    bus_access("fh_clr", A_FROM, 1'b1, 32'h0000_1234, 1'b1);
    bus_access("fh_rd1", A_FROM, 1'b0, 32'h0, 1'b1);
    check_output("fh_rd1_rdata", data_rdata_o, 32'h0);
    fromhost_we_i   = 1'b1;
    fromhost_data_i = 32'h0000_005A;
    bus_access("fh_race", A_FROM, 1'b1, 32'h0, 1'b1);
    fromhost_we_i   = 1'b0;
    bus_access("fh_rd2", A_FROM, 1'b0, 32'h0, 1'b1);
    check_output("fh_rd2_rdata", data_rdata_o, 32'h0000_005A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
